// File: rtl/ls2hs_pkg.sv
// ---------------------------------------------------------------------------
// ls2hs_pkg
// Shared constants and the round-robin pick helper for the low-speed to
// high-speed transfer scheduler.
// Contents:
//   NUM_SRC_DEF / DW_DEF : default source count and data width
//   MAX_SRC              : widest pending vector rr_pick accepts
//   rr_pick()            : next pending index after 'last', wrapping
// ---------------------------------------------------------------------------
package ls2hs_pkg;

   localparam int NUM_SRC_DEF = 4;
   localparam int DW_DEF      = 8;
   localparam int MAX_SRC     = 8;

   // First set bit of 'pending' searching upward from last+1 and wrapping
   // at num_src. Returns 0 when nothing is pending; callers qualify with
   // an OR-reduce of the pending vector.
   function automatic int rr_pick(input logic [MAX_SRC-1:0] pending,
                                  input int                 last,
                                  input int                 num_src);
      int   pick_v;
      logic found_v;
      int   idx_v;
      pick_v  = 0;
      found_v = 1'b0;
      for (int k = 1; k <= MAX_SRC; k++) begin
         idx_v = last + k;
         if (idx_v >= num_src) begin
            idx_v = idx_v - num_src;
         end else begin
            idx_v = idx_v;
         end
         if ((k <= num_src) && !found_v && pending[idx_v[2:0]]) begin
            pick_v  = idx_v;
            found_v = 1'b1;
         end else begin
            pick_v  = pick_v;
         end
      end
      return pick_v;
   endfunction

endpackage

// File: rtl/ls2hs_edge_sync.sv
// ---------------------------------------------------------------------------
// ls2hs_edge_sync
// Brings one slow strobe into rclk through two synchroniser flops, keeps a
// third history flop, and flags the rising edge for exactly one rclk cycle.
// Ports:
//   rclk     in  : fast clock
//   rst      in  : synchronous active-high reset
//   async_in in  : strobe, asynchronous to rclk
//   edge_out out : high for one cycle, two rclk edges after the rise is
//                  first sampled
// ---------------------------------------------------------------------------
module ls2hs_edge_sync (
   input  logic rclk,
   input  logic rst,
   input  logic async_in,
   output logic edge_out
);

   logic s1_r;
   logic s2_r;
   logic s3_r;

   // Synchroniser chain plus history flop; reset clears all three so a
   // strobe held high through reset shows up as a fresh edge afterwards.
   always_ff @(posedge rclk) begin
      if (rst) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= async_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   assign edge_out = s2_r & ~s3_r;

endmodule

// File: rtl/ls2hs_xfer_sched.sv
// ---------------------------------------------------------------------------
// ls2hs_xfer_sched
// Round-robin scheduler sharing one rclk output register among NUM_SRC slow
// sources. Each source's strobe rise captures its data byte into a holding
// register; pending words leave through a valid/ready port tagged with the
// source index.
// Ports:
//   rclk      in  : fast clock, the only clock
//   rst       in  : synchronous active-high reset
//   src_clk   in  : [NUM_SRC] slow strobes, bit i = source i
//   src_din   in  : [NUM_SRC*DW] source data, slice i = [i*DW +: DW]
//   out_data  out : granted word
//   out_src   out : index of the source that produced out_data
//   out_valid out : output register holds a word
//   out_ready in  : consumer accepts when out_valid & out_ready
//   overrun   out : [NUM_SRC] sticky data-loss flags
//   ovr_clr   in  : clears all overrun bits (a same-cycle set wins)
// ---------------------------------------------------------------------------
module ls2hs_xfer_sched
   import ls2hs_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int DW      = DW_DEF,
   parameter int SW      = $clog2(NUM_SRC)
) (
   input  logic                  rclk,
   input  logic                  rst,
   input  logic [NUM_SRC-1:0]    src_clk,
   input  logic [NUM_SRC*DW-1:0] src_din,
   output logic [DW-1:0]         out_data,
   output logic [SW-1:0]         out_src,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NUM_SRC-1:0]    overrun,
   input  logic                  ovr_clr
);

   logic [NUM_SRC-1:0] edge_s;
   logic [DW-1:0]      hold_r [NUM_SRC];
   logic [NUM_SRC-1:0] pending_r;
   logic [NUM_SRC-1:0] overrun_r;
   logic [NUM_SRC-1:0] ovr_set_s;
   logic [NUM_SRC-1:0] grant_vec_s;
   logic [MAX_SRC-1:0] pend_pad_s;
   logic [SW-1:0]      last_grant_r;
   logic [SW-1:0]      pick_s;
   logic               load_s;
   logic               grant_s;
   logic [DW-1:0]      out_data_r;
   logic [SW-1:0]      out_src_r;
   logic               out_valid_r;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      ls2hs_edge_sync u_sync (
         .rclk     (rclk),
         .rst      (rst),
         .async_in (src_clk[g]),
         .edge_out (edge_s[g])
      );
   end

   // Arbitration: decide whether the output register loads and which
   // pending source, if any, moves into it.
   always_comb begin
      pend_pad_s                = '0;
      pend_pad_s[NUM_SRC-1:0]   = pending_r;
      pick_s                    = SW'(rr_pick(pend_pad_s, int'(last_grant_r), NUM_SRC));
      load_s                    = ~out_valid_r | out_ready;
      grant_s                   = load_s & (|pending_r);
      grant_vec_s               = '0;
      if (grant_s) begin
         grant_vec_s[pick_s]    = 1'b1;
      end else begin
         grant_vec_s            = '0;
      end
      // A granted source frees its slot this cycle, so its edge is not a loss.
      ovr_set_s                 = edge_s & pending_r & ~grant_vec_s;
   end

   // Per-source holding registers, pending flags and sticky overrun flags.
   always_ff @(posedge rclk) begin
      if (rst) begin
         pending_r <= '0;
         overrun_r <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            hold_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            // Load when the slot is empty or is being emptied this cycle.
            if (edge_s[i] && (!pending_r[i] || grant_vec_s[i])) begin
               hold_r[i]    <= src_din[i*DW +: DW];
               pending_r[i] <= 1'b1;
            end else if (grant_vec_s[i]) begin
               pending_r[i] <= 1'b0;
            end else begin
               pending_r[i] <= pending_r[i];
            end
         end
         if (ovr_clr) begin
            overrun_r <= ovr_set_s;
         end else begin
            overrun_r <= overrun_r | ovr_set_s;
         end
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge rclk) begin
      if (rst) begin
         out_data_r   <= '0;
         out_src_r    <= '0;
         out_valid_r  <= 1'b0;
         last_grant_r <= SW'(NUM_SRC - 1);
      end else if (load_s) begin
         if (grant_s) begin
            out_data_r   <= hold_r[pick_s];
            out_src_r    <= pick_s;
            out_valid_r  <= 1'b1;
            last_grant_r <= pick_s;
         end else begin
            out_valid_r  <= 1'b0;
         end
      end else begin
         out_valid_r  <= out_valid_r;
      end
   end

   assign out_data  = out_data_r;
   assign out_src   = out_src_r;
   assign out_valid = out_valid_r;
   assign overrun   = overrun_r;

endmodule

// File: tb/tb_ls2hs_xfer_sched.sv
// ---------------------------------------------------------------------------
// tb_ls2hs_xfer_sched
// Self-checking bench: a per-cycle vector table, hand-written corner-case
// sequences and randomized strobes, all compared every cycle against a
// transaction-level reference model of the scheduler's rules.
// ---------------------------------------------------------------------------
module tb_ls2hs_xfer_sched;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int SW = 2;

   logic             rclk = 1'b0;
   logic             rst;
   logic [N-1:0]     src_clk;
   logic [N*DW-1:0]  src_din;
   logic [DW-1:0]    out_data;
   logic [SW-1:0]    out_src;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     overrun;
   logic             ovr_clr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 rclk = ~rclk;

   ls2hs_xfer_sched #(.NUM_SRC(N), .DW(DW), .SW(SW)) dut (
      .rclk      (rclk),
      .rst       (rst),
      .src_clk   (src_clk),
      .src_din   (src_din),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr)
   );

   // values the bench applies at the next falling edge
   logic [N-1:0]  d_src;
   logic [DW-1:0] d_din [N];
   logic          d_rdy;
   logic          d_clr;
   logic          d_rst;

   // reference model: slots, round-robin pointer, output register contents
   int            cyc;
   int            due [N];
   logic [N-1:0]  m_seen;
   logic [N-1:0]  m_pend;
   logic [N-1:0]  m_ovr;
   logic [DW-1:0] m_word [N];
   logic [DW-1:0] m_od;
   int            m_os;
   int            m_last;
   logic          m_ov;

   typedef struct {
      logic            rst;
      logic [N-1:0]    src;
      logic [N*DW-1:0] din;
      logic            rdy;
      logic            ev;
      logic [DW-1:0]   ed;
      logic [SW-1:0]   es;
   } vec_t;

   vec_t tbl [23];

   function automatic vec_t mk(input logic r, input logic [N-1:0] s,
                               input logic [N*DW-1:0] d, input logic ev,
                               input logic [DW-1:0] ed, input logic [SW-1:0] es);
      vec_t v;
      v.rst = r; v.src = s; v.din = d; v.rdy = 1'b1;
      v.ev = ev; v.ed = ed; v.es = es;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_ovr = '0; m_seen = '0; m_ov = 1'b0;
      m_od = '0; m_os = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) begin
         m_word[i] = '0;
         due[i]    = -1;
      end
   endtask

   // One rclk edge of the scheduler's rules.
   task automatic model_update();
      logic [N-1:0] ev;
      logic [N-1:0] nov;
      int g;
      if (d_rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < N; i++) begin
            ev[i] = (due[i] == cyc);
            if (d_src[i] && !m_seen[i]) due[i] = cyc + 2;
         end
         m_seen = d_src;
         g = -1;
         if (!m_ov || d_rdy) begin
            for (int k = 1; k <= N; k++)
               if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
            if (g >= 0) begin
               m_od = m_word[g]; m_os = g; m_ov = 1'b1; m_last = g;
            end else begin
               m_ov = 1'b0;
            end
         end
         nov = '0;
         for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
               if (i == g) m_word[i] = d_din[i];
               else if (m_pend[i]) nov[i] = 1'b1;
               else begin m_word[i] = d_din[i]; m_pend[i] = 1'b1; end
            end else if (i == g) begin
               m_pend[i] = 1'b0;
            end
         end
         m_ovr = (d_clr ? '0 : m_ovr) | nov;
      end
   endtask

   task automatic step();
      @(negedge rclk);
      rst = d_rst; out_ready = d_rdy; ovr_clr = d_clr; src_clk = d_src;
      for (int i = 0; i < N; i++) src_din[i*DW +: DW] = d_din[i];
      @(posedge rclk);
      cyc++;
      model_update();
      #1;
      chk("valid", 32'(out_valid), 32'(m_ov));
      if (m_ov || d_rst) begin
         chk("data", 32'(out_data), 32'(m_od));
         chk("src", 32'(out_src), 32'(m_os));
      end
      chk("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int ph [N];

   initial begin
      logic [N*DW-1:0] da, db, dc;
      rst = 1'b1; out_ready = 1'b0; ovr_clr = 1'b0; src_clk = '0; src_din = '0;
      d_rst = 1'b1; d_rdy = 1'b0; d_clr = 1'b0; d_src = '0;
      for (int i = 0; i < N; i++) d_din[i] = '0;
      cyc = 0;
      model_reset();

      // ---- vector table: strobe held through reset, single source, all four
      da = {8'h00, 8'h3C, 8'h00, 8'h00};
      db = {8'h00, 8'h00, 8'hA5, 8'h00};
      dc = {8'h44, 8'h33, 8'h22, 8'h11};
      tbl[0]  = mk(1'b1, 4'b0100, da, 1'b0, 8'h00, 2'd0);
      tbl[1]  = mk(1'b0, 4'b0100, da, 1'b0, 8'h00, 2'd0);
      tbl[2]  = mk(1'b0, 4'b0100, da, 1'b0, 8'h00, 2'd0);
      tbl[3]  = mk(1'b0, 4'b0100, da, 1'b0, 8'h00, 2'd0);
      tbl[4]  = mk(1'b0, 4'b0000, da, 1'b1, 8'h3C, 2'd2);
      tbl[5]  = mk(1'b0, 4'b0000, da, 1'b0, 8'h00, 2'd0);
      tbl[6]  = mk(1'b0, 4'b0000, db, 1'b0, 8'h00, 2'd0);
      tbl[7]  = mk(1'b0, 4'b0000, db, 1'b0, 8'h00, 2'd0);
      tbl[8]  = mk(1'b0, 4'b0010, db, 1'b0, 8'h00, 2'd0);
      tbl[9]  = mk(1'b0, 4'b0010, db, 1'b0, 8'h00, 2'd0);
      tbl[10] = mk(1'b0, 4'b0010, db, 1'b0, 8'h00, 2'd0);
      tbl[11] = mk(1'b0, 4'b0000, db, 1'b1, 8'hA5, 2'd1);
      tbl[12] = mk(1'b0, 4'b0000, db, 1'b0, 8'h00, 2'd0);
      tbl[13] = mk(1'b1, 4'b0000, dc, 1'b0, 8'h00, 2'd0);
      tbl[14] = mk(1'b0, 4'b0000, dc, 1'b0, 8'h00, 2'd0);
      tbl[15] = mk(1'b0, 4'b1111, dc, 1'b0, 8'h00, 2'd0);
      tbl[16] = mk(1'b0, 4'b1111, dc, 1'b0, 8'h00, 2'd0);
      tbl[17] = mk(1'b0, 4'b1111, dc, 1'b0, 8'h00, 2'd0);
      tbl[18] = mk(1'b0, 4'b0000, dc, 1'b1, 8'h11, 2'd0);
      tbl[19] = mk(1'b0, 4'b0000, dc, 1'b1, 8'h22, 2'd1);
      tbl[20] = mk(1'b0, 4'b0000, dc, 1'b1, 8'h33, 2'd2);
      tbl[21] = mk(1'b0, 4'b0000, dc, 1'b1, 8'h44, 2'd3);
      tbl[22] = mk(1'b0, 4'b0000, dc, 1'b0, 8'h00, 2'd0);
      for (int r = 0; r < 23; r++) begin
         d_rst = tbl[r].rst; d_src = tbl[r].src; d_rdy = tbl[r].rdy;
         for (int i = 0; i < N; i++) d_din[i] = tbl[r].din[i*DW +: DW];
         step();
         chk("tbl_valid", 32'(out_valid), 32'(tbl[r].ev));
         if (tbl[r].ev || tbl[r].rst) begin
            chk("tbl_data", 32'(out_data), 32'(tbl[r].ed));
            chk("tbl_src", 32'(out_src), 32'(tbl[r].es));
         end
         chk("tbl_overrun", 32'(overrun), 32'd0);
      end

      // ---- backpressure: sources 2 and 3 pending, consumer stalled
      d_rdy = 1'b0; d_din[2] = 8'h2B; d_din[3] = 8'h3B;
      step();
      d_src = 4'b1100; run(3);
      d_src = 4'b0000; step();
      chk("bp_first_src", 32'(out_src), 32'd2);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_src", 32'(out_src), 32'd2);
         chk("bp_hold_data", 32'(out_data), 32'h2B);
      end
      d_rdy = 1'b1; step();
      chk("bp_next_src", 32'(out_src), 32'd3);
      chk("bp_next_data", 32'(out_data), 32'h3B);
      step();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // ---- overrun: output busy with source 3, source 0 strobes twice
      d_rdy = 1'b0; d_din[3] = 8'h77; step();
      d_src = 4'b1000; run(3);
      d_src = 4'b0000; d_din[0] = 8'h5A; run(3);
      d_src = 4'b0001; run(3);
      d_src = 4'b0000; run(2); d_din[0] = 8'hC3; step();
      d_src = 4'b0001; run(3);
      chk("ovr_set", 32'(overrun), 32'h1);
      d_src = 4'b0000; run(3);
      d_rdy = 1'b1; step();
      chk("ovr_first_word", 32'(out_data), 32'h5A);
      chk("ovr_first_src", 32'(out_src), 32'd0);
      step();
      chk("ovr_sticky", 32'(overrun), 32'h1);
      d_clr = 1'b1; step(); d_clr = 1'b0;
      chk("ovr_cleared", 32'(overrun), 32'h0);

      // ---- grant of source 1 in the same cycle its next edge lands
      d_rdy = 1'b0; d_din[3] = 8'h13; step();
      d_src = 4'b1000; run(3);
      d_src = 4'b0000; d_din[1] = 8'h6D; run(3);
      d_src = 4'b0010; run(3);
      d_src = 4'b0000; run(2); d_din[1] = 8'h7E; step();
      d_src = 4'b0010; run(2);
      d_rdy = 1'b1; step();
      chk("same_old_word", 32'(out_data), 32'h6D);
      chk("same_old_src", 32'(out_src), 32'd1);
      d_src = 4'b0000; step();
      chk("same_new_word", 32'(out_data), 32'h7E);
      chk("same_new_valid", 32'(out_valid), 32'd1);
      step();
      chk("same_no_ovr", 32'(overrun), 32'h0);
      chk("same_drained", 32'(out_valid), 32'd0);

      // ---- reset while a word is presented and three more are pending
      d_rdy = 1'b0;
      for (int i = 0; i < N; i++) d_din[i] = 8'hA0 + 8'(i);
      step();
      d_src = 4'b1111; run(3);
      d_src = 4'b0000; run(3);
      chk("mid_busy", 32'(out_valid), 32'd1);
      d_rst = 1'b1; step(); d_rst = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_src", 32'(out_src), 32'd0);
      d_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("mid_no_stale", 32'(out_valid), 32'd0);
      end

      // ---- randomized strobes, backpressure, clears and rare resets
      for (int i = 0; i < N; i++) ph[i] = 3;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (ph[i] >= 3 && $urandom_range(0, 3) == 0) begin
               d_src[i] = ~d_src[i];
               ph[i] = 1;
               if (!d_src[i]) d_din[i] = 8'($urandom);
            end else begin
               ph[i]++;
            end
         end
         d_rdy = ($urandom_range(0, 9) < 6);
         d_clr = ($urandom_range(0, 19) == 0);
         d_rst = ($urandom_range(0, 399) == 0);
         step();
      end
      d_rst = 1'b0; d_clr = 1'b0; d_rdy = 1'b1; d_src = '0;
      run(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
